spi_rect_fill: RTL
==================

// Module: spi_rect_fill
// PURPOSE
// Sequencer that paints a solid RGB565 rectangle on the SPI LCD after spi_init reports done.
// Emits the command/data byte stream CASET(0x2A), PASET(0x2B), RAMWR(0x2C), then pixel data.
// Drives a downstream byte-level SPI transmitter through a valid/ready handshake plus a D/C flag.
// Sits beside spi_init under the SPI top; the top muxes the transmitter and starts this block after init.
// PARAMETERS
// H_RES    240   panel width in pixels; legal x range 0..H_RES-1
// V_RES    320   panel height in pixels; legal y range 0..V_RES-1
// PORTS
// i_clk       in   1   system clock
// i_rst       in   1   asynchronous, active-high reset
// i_start     in   1   one-cycle request; sampled only in IDLE
// i_x0,i_x1   in   16  column start/end, inclusive
// i_y0,i_y1   in   16  row start/end, inclusive
// i_color     in   16  RGB565 fill colour
// o_tx_valid  out  1   byte on o_tx_data/o_tx_dc is valid
// o_tx_data   out  8   byte to transmit
// o_tx_dc     out  1   0 = command byte, 1 = data byte
// i_tx_ready  in   1   transmitter accepts the byte this cycle
// o_busy      out  1   high from the cycle after start is accepted until return to IDLE
// o_done      out  1   one-cycle pulse after the last pixel byte is accepted
// o_err       out  1   one-cycle pulse on a rejected request
// BEHAVIOUR
// - Reset: state IDLE; o_tx_valid=0, o_tx_data=0, o_tx_dc=0, o_busy=0, o_done=0, o_err=0; counters cleared.
// - Transfer occurs on a cycle with o_tx_valid && i_tx_ready. Data/dc are held stable while valid and not ready.
// - o_tx_valid never drops before acceptance. Next byte is presented the cycle after acceptance
//   (valid may stay high continuously, giving 1 byte/cycle at full ready).
// - IDLE + i_start: latch coordinates and colour; validate x0<=x1<H_RES and y0<=y1<V_RES.
//   Invalid: o_err pulses the next cycle, no byte is emitted, o_done is not asserted, state stays IDLE.
//   Valid: go to CASET_CMD; o_busy=1 and o_tx_valid=1 with 0x2A the next cycle (latency 1).
// - States and byte order (dc in brackets):
//   CASET_CMD  0x2A[0]                        -> CASET_DATA
//   CASET_DATA x0[15:8],x0[7:0],x1[15:8],x1[7:0] [1]  -> PASET_CMD
//   PASET_CMD  0x2B[0]                        -> PASET_DATA
//   PASET_DATA y0[15:8],y0[7:0],y1[15:8],y1[7:0] [1]  -> RAMWR_CMD
//   RAMWR_CMD  0x2C[0]                        -> PIXELS
//   PIXELS     color[15:8],color[7:0] [1], repeated N times -> DONE
//   DONE       o_done=1 for one cycle, o_busy=0, valid=0  -> IDLE
// - Each state advances only on acceptance of its last byte; 2-bit byte index within 4-byte data states.
// - N=(x1-x0+1)*(y1-y0+1), computed once at latch; pixel counter 17 bits (max 76800), no wrap.
// - Total bytes per request = 11 + 2*N.
// - i_start while busy is ignored; latched values never change mid-operation.
// - Async reset mid-operation: outputs return to reset values immediately; no done/err pulse.
// - o_done and o_err are never high in the same cycle.
// TESTING
// 1x1 at (0,0), color 0xF800, ready=1 -> bytes 2A 00 00 00 00 2B 00 00 00 00 2C F8 00,
//   dc 0,1x4,0,1x4,0,1,1; o_done one cycle after final accept; 13 consecutive valid cycles.
// Rect x=10..19, y=300..301, color 0x07E0 -> CASET data 00 0A 00 13, PASET 01 2C 01 2D,
//   40 pixel bytes alternating 07,E0; total 51 bytes.
// Random i_tx_ready backpressure on 3x3 fill -> byte stream identical to ready=1 run;
//   data/dc stable while valid && !ready.
// x1=240 (or x0=5,x1=4, or y1=320) -> o_err pulse one cycle after start;
//   o_tx_valid stays 0; o_done never rises.
// i_start pulsed during PIXELS with new coords -> ignored; stream and o_done match the first request.
// Full screen 0..239 x 0..319 -> 153611 bytes, o_done once; assert i_rst during PIXELS
//   -> valid/busy low immediately, new start afterwards runs cleanly.

Source files
------------

// File: rtl/spi_rect_fill.sv
// rtl/spi_rect_fill.sv - paints a solid RGB565 rectangle on the SPI LCD
// Emits CASET/PASET/RAMWR plus pixel bytes to a byte-level transmitter over valid/ready.
module spi_rect_fill #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_y1,
  input  logic [15:0] i_color,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_dc,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET_CMD, S_CASET_DATA, S_PASET_CMD,
    S_PASET_DATA, S_RAMWR_CMD, S_PIXELS, S_DONE
  } state_t;

  localparam logic [15:0] X_LIM = 16'(H_RES);
  localparam logic [15:0] Y_LIM = 16'(V_RES);

  state_t      state, state_nx;
  logic [15:0] x0_q, x1_q, y0_q, y1_q, color_q;
  logic [16:0] npix_q, pix_cnt;
  logic [1:0]  byte_idx;
  logic        err_q;

  logic        req_ok;
  logic        accept;
  logic        last_pixel;
  logic [16:0] width, height;
  logic [31:0] coord_word;

  assign req_ok = (i_x0 <= i_x1) && (i_x1 < X_LIM) && (i_y0 <= i_y1) && (i_y1 < Y_LIM);
  assign width  = {1'b0, i_x1 - i_x0} + 17'd1;
  assign height = {1'b0, i_y1 - i_y0} + 17'd1;
  assign accept = o_tx_valid && i_tx_ready;
  // A pixel completes when its low colour byte is accepted.
  assign last_pixel = byte_idx[0] && (pix_cnt == npix_q - 17'd1);
  assign coord_word = (state == S_CASET_DATA) ? {x0_q, x1_q} : {y0_q, y1_q};
  assign o_err = err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      npix_q   <= '0;
      pix_cnt  <= '0;
      byte_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= 1'b0;
      if (state == S_IDLE) begin
        pix_cnt  <= '0;
        byte_idx <= '0;
        if (i_start) begin
          if (req_ok) begin
            x0_q    <= i_x0;
            x1_q    <= i_x1;
            y0_q    <= i_y0;
            y1_q    <= i_y1;
            color_q <= i_color;
            npix_q  <= 17'(width * height);
          end else begin
            err_q <= 1'b1;
          end
        end
      end
      if (accept && (state == S_CASET_DATA || state == S_PASET_DATA || state == S_PIXELS))
        byte_idx <= byte_idx + 2'd1;
      if (accept && state == S_PIXELS && byte_idx[0])
        pix_cnt <= pix_cnt + 17'd1;
      if (state == S_DONE) begin
        pix_cnt  <= '0;
        byte_idx <= '0;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_tx_dc    = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start && req_ok) state_nx = S_CASET_CMD;
      end
      S_CASET_CMD: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h2A;
        if (accept) state_nx = S_CASET_DATA;
      end
      S_CASET_DATA, S_PASET_DATA: begin
        o_tx_valid = 1'b1;
        o_tx_dc    = 1'b1;
        case (byte_idx)
          2'd0:    o_tx_data = coord_word[31:24];
          2'd1:    o_tx_data = coord_word[23:16];
          2'd2:    o_tx_data = coord_word[15:8];
          default: o_tx_data = coord_word[7:0];
        endcase
        if (accept && byte_idx == 2'd3)
          state_nx = (state == S_CASET_DATA) ? S_PASET_CMD : S_RAMWR_CMD;
      end
      S_PASET_CMD: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h2B;
        if (accept) state_nx = S_PASET_DATA;
      end
      S_RAMWR_CMD: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h2C;
        if (accept) state_nx = S_PIXELS;
      end
      S_PIXELS: begin
        o_tx_valid = 1'b1;
        o_tx_dc    = 1'b1;
        o_tx_data  = byte_idx[0] ? color_q[7:0] : color_q[15:8];
        if (accept && last_pixel) state_nx = S_DONE;
      end
      S_DONE: begin
        o_busy   = 1'b0;
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        o_busy   = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
